stepper_move_ctrl: RTL and testbench
====================================

STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the step-count field.
REQ-002 Parameter DIV_W, default 16: width of the step-period field, in clock cycles.
REQ-003 Parameter SETTLE_CYC, default 4: hold cycles after the last step, before done.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  move command offered.
REQ-007 cmd_ready  out  1  controller can accept a command.
REQ-008 cmd_steps  in  CNT_W  number of steps to move (unsigned).
REQ-009 cmd_dir  in  1  0 = CW, 1 = CCW.
REQ-010 cmd_period  in  DIV_W  cycles between step pulses.
REQ-011 abort  in  1  stop the current move early.
REQ-012 step_en  out  1  one-cycle step pulse to the stepper enable input.
REQ-013 step_dir  out  1  direction to the stepper dir input.
REQ-014 busy  out  1  a move is in progress (RUN or SETTLE).
REQ-015 done  out  1  one-cycle pulse when a move completes or is aborted.
REQ-016 aborted  out  1  qualifies done: 1 if the move ended by abort.
REQ-017 steps_left  out  CNT_W  steps still to issue.

Function
REQ-018 FSM states: IDLE, RUN, SETTLE; cmd_ready=1 only in IDLE; busy=1 in RUN and SETTLE.
REQ-019 Accept occurs when cmd_valid & cmd_ready: latch steps, dir and P_eff = max(cmd_period,1); step_dir <= cmd_dir.
REQ-020 Accept with cmd_steps=0: no step_en; go to SETTLE directly.
REQ-021 Accept with cmd_steps>0: go to RUN; steps_left <= cmd_steps.
REQ-022 First step_en: exactly P_eff cycles after the accept edge; each later step_en follows the previous one by exactly P_eff cycles.
REQ-023 Each step_en cycle decrements steps_left by 1; the new value is visible on the next cycle; steps_left never wraps below 0.
REQ-024 After the step_en that takes steps_left to 0: enter SETTLE; no further step_en.
REQ-025 SETTLE lasts SETTLE_CYC cycles, then IDLE. done=1 on the first IDLE cycle; cmd_ready is also 1 that cycle.
REQ-026 step_dir changes only on accept; it is stable during RUN, SETTLE and IDLE.
REQ-027 abort in RUN: takes priority over a step_en due the same cycle (that pulse is suppressed). Go to SETTLE; aborted <= 1; steps_left holds its remaining value.
REQ-028 abort in IDLE or SETTLE is ignored.
REQ-029 aborted is valid with done and stays valid until the next accept, which clears it to 0.
REQ-030 The period timer is a down-counter of width DIV_W. P_eff = 2^DIV_W-1 is legal and does not overflow.
REQ-031 cmd_valid while busy: no accept and no side effect; the command is taken later when cmd_ready returns.

Reset
REQ-032 While rst=1: state=IDLE, cmd_ready=0, step_en=0, step_dir=0, busy=0, done=0, aborted=0, steps_left=0, timer=0.
REQ-033 The first cycle after rst deasserts has cmd_ready=1.
REQ-034 rst during RUN or SETTLE: the move is discarded, no done pulse, and step_en=0 from the reset cycle onward.

Structure
REQ-035 Shared package stepper_pkg holds: the FSM state enum (IDLE/RUN/SETTLE), default CNT_W/DIV_W/SETTLE_CYC constants, and the CW/CCW direction constants.
REQ-036 One sub-module, step_rate_timer: loadable down-counter that emits a one-cycle tick on expiry and auto-reloads P_eff. It is instantiated once.

Verification
REQ-037 Accept steps=3, period=5, dir=0: step_en exactly 5, 10 and 15 cycles after accept; step_dir=0 throughout; done=1, aborted=0 exactly 15+SETTLE_CYC(4)+1=20 cycles after accept.
REQ-038 Accept steps=4, period=0: P_eff=1, so step_en high on 4 consecutive cycles starting 1 cycle after accept; steps_left reads 4,3,2,1,0.
REQ-039 Accept steps=10, period=3, then abort on the cycle of the 3rd step_en: 3rd pulse suppressed, only 2 step_en seen, steps_left=8 held, done=1 with aborted=1.
REQ-040 Accept steps=0: no step_en; done=1 exactly SETTLE_CYC+1=5 cycles after accept.
REQ-041 Hold cmd_valid with dir=1 during a dir=0 move: no accept and step_dir stays 0 until the done cycle; the next move is accepted on the first IDLE cycle and step_dir becomes 1.
REQ-042 Assert rst for 1 cycle mid-RUN (steps=5, period=2): no further step_en, no done pulse, all outputs at reset values, cmd_ready=1 on the next cycle.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and defaults for the stepper move controller.
package stepper_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StSettle
  } state_e;

  localparam int unsigned DefCntW      = 16;
  localparam int unsigned DefDivW      = 16;
  localparam int unsigned DefSettleCyc = 4;

  localparam logic DirCw  = 1'b0;
  localparam logic DirCcw = 1'b1;

endpackage

// File: rtl/step_rate_timer.sv
// Loadable step-period down-counter: one-cycle tick on expiry, then reloads the latched period.
module step_rate_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic             run_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] reload_q, reload_d;

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tick_o   = run_i && !load_i && (cnt_q == DIV_W'(1));
    if (load_i) begin
      cnt_d    = load_val_i;
      reload_d = load_val_i;
    end else if (run_i) begin
      // Reload instead of passing through zero keeps the step spacing exact.
      cnt_d = (cnt_q == DIV_W'(1)) ? reload_q : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: accepts a move command, issues paced step pulses, settles, reports done.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned DIV_W      = DefDivW,
  parameter int unsigned SETTLE_CYC = DefSettleCyc  // must be at least 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             step_en,
  output logic             step_dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic             dir_q, dir_d;
  logic             aborted_q, aborted_d;
  logic             done_q, done_d;

  logic             accept;
  logic             tick;
  logic             step_int;
  logic [DIV_W-1:0] p_eff;

  assign p_eff  = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
  assign accept = cmd_valid && (state_q == StIdle);

  step_rate_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (accept),
    .load_val_i(p_eff),
    .run_i     (state_q == StRun),
    .tick_o    (tick)
  );

  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    settle_d  = settle_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    step_int  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          dir_d     = cmd_dir;
          aborted_d = 1'b0;
          settle_d  = '0;
          steps_d   = cmd_steps;
          state_d   = (cmd_steps == '0) ? StSettle : StRun;
        end
      end
      StRun: begin
        // Abort wins over a step falling due in the same cycle.
        if (abort) begin
          aborted_d = 1'b1;
          settle_d  = '0;
          state_d   = StSettle;
        end else if (tick && steps_q != '0) begin
          step_int = 1'b1;
          steps_d  = steps_q - CNT_W'(1);
          if (steps_q == CNT_W'(1)) begin
            settle_d = '0;
            state_d  = StSettle;
          end
        end
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      steps_q   <= '0;
      settle_q  <= '0;
      dir_q     <= DirCw;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      settle_q  <= settle_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
    end
  end

  // Outputs are forced to their reset values for the whole cycle rst is high.
  assign cmd_ready  = (state_q == StIdle) && !rst;
  assign step_en    = step_int && !rst;
  assign busy       = (state_q != StIdle) && !rst;
  assign done       = done_q && !rst;
  assign aborted    = aborted_q && !rst;
  assign step_dir   = dir_q && !rst;
  assign steps_left = rst ? '0 : steps_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl against an arithmetic per-cycle move model.
module tb_stepper_move_ctrl;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DIV_W  = 8;
  localparam int          SETTLE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [DIV_W-1:0] cmd_period;
  logic             abort;
  logic             step_en;
  logic             step_dir;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_left;

  int n_tests = 0;
  int n_fail  = 0;

  stepper_move_ctrl #(
    .CNT_W     (CNT_W),
    .DIV_W     (DIV_W),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .cmd_period(cmd_period),
    .abort     (abort),
    .step_en   (step_en),
    .step_dir  (step_dir),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_sample();
    @(negedge clk);
  endtask

  function automatic int p_eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  // Expected outputs r cycles after the accept cycle of a move (N steps, period P, abort at ab_at).
  task automatic check_cycle(input int r, input int n, input int p, input int dir, input int ab_at);
    int  pe;
    int  nat;
    bit  ab;
    int  end_r;
    int  done_r;
    bit  se;
    int  sl;
    pe     = p_eff(p);
    nat    = n * pe;
    ab     = (n > 0) && (ab_at >= 1) && (ab_at <= nat);
    end_r  = ab ? ab_at : nat;
    done_r = end_r + SETTLE + 1;
    se     = (r >= 1) && (r <= end_r) && (r % pe == 0) && !(ab && r == ab_at);
    if (r <= end_r) sl = n - (r - 1) / pe;
    else            sl = ab ? n - (ab_at - 1) / pe : 0;
    chk($sformatf("step_en r=%0d", r), int'(step_en), int'(se));
    chk($sformatf("steps_left r=%0d", r), int'(steps_left), sl);
    chk($sformatf("busy r=%0d", r), int'(busy), int'(r <= end_r + SETTLE));
    chk($sformatf("done r=%0d", r), int'(done), int'(r == done_r));
    chk($sformatf("cmd_ready r=%0d", r), int'(cmd_ready), int'(r == done_r));
    chk($sformatf("step_dir r=%0d", r), int'(step_dir), dir);
    chk($sformatf("aborted r=%0d", r), int'(aborted), int'(ab && r > ab_at));
  endtask

  // Runs one move through its done cycle; optionally holds the next command valid meanwhile.
  task automatic run_move(input int n, input int p, input int dir, input int ab_at,
                          input bit pre, input bit nxt, input int nn, input int np,
                          input int ndir);
    int pe;
    int nat;
    int done_r;
    pe     = p_eff(p);
    nat    = n * pe;
    done_r = (((n > 0) && (ab_at >= 1) && (ab_at <= nat)) ? ab_at : nat) + SETTLE + 1;
    if (!pre) begin
      cyc_start();
      cmd_valid  = 1'b1;
      cmd_steps  = CNT_W'(n);
      cmd_period = DIV_W'(p);
      cmd_dir    = dir[0];
      abort      = 1'b0;
      cyc_sample();
      chk("accept cmd_ready", int'(cmd_ready), 1);
      chk("accept step_en", int'(step_en), 0);
    end
    for (int r = 1; r <= done_r; r++) begin
      cyc_start();
      cmd_valid = nxt;
      if (nxt) begin
        cmd_steps  = CNT_W'(nn);
        cmd_period = DIV_W'(np);
        cmd_dir    = ndir[0];
      end else begin
        cmd_steps  = CNT_W'($urandom);
        cmd_period = DIV_W'($urandom);
        cmd_dir    = 1'($urandom);
      end
      abort = (r == ab_at);
      cyc_sample();
      check_cycle(r, n, p, dir, ab_at);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cyc_start();
      cmd_valid = 1'b0;
      abort     = 1'($urandom);
      cyc_sample();
      chk("idle cmd_ready", int'(cmd_ready), 1);
      chk("idle busy", int'(busy), 0);
      chk("idle step_en", int'(step_en), 0);
      chk("idle done", int'(done), 0);
    end
    abort = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, int'(cmd_ready), 0);
    chk({tag, " step_en"}, int'(step_en), 0);
    chk({tag, " step_dir"}, int'(step_dir), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " aborted"}, int'(aborted), 0);
    chk({tag, " steps_left"}, int'(steps_left), 0);
  endtask

  initial begin
    int n;
    int p;
    int ab_at;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_dir    = 1'b0;
    cmd_period = '0;
    abort      = 1'b0;

    // Reset and the first cycle after release
    cyc_start();
    cyc_sample();
    chk_reset_outputs("reset");
    cyc_start();
    rst = 1'b0;
    cyc_sample();
    chk("post-reset cmd_ready", int'(cmd_ready), 1);
    chk("post-reset busy", int'(busy), 0);

    // Directed moves
    run_move(3, 5, 0, 0, 1'b0, 1'b0, 0, 0, 0);
    idle(2);
    run_move(4, 0, 1, 0, 1'b0, 1'b0, 0, 0, 0);
    idle(1);
    run_move(10, 3, 0, 9, 1'b0, 1'b0, 0, 0, 0);
    idle(1);
    run_move(0, 7, 1, 0, 1'b0, 1'b0, 0, 0, 0);
    idle(1);
    run_move(2, 2, 0, 0, 1'b0, 1'b1, 3, 1, 1);
    run_move(3, 1, 1, 0, 1'b1, 1'b0, 0, 0, 0);
    idle(1);
    run_move(1, 255, 1, 0, 1'b0, 1'b0, 0, 0, 0);
    idle(1);

    // Reset in the middle of a move, on a cycle where a step is due
    run_move(5, 2, 1, 0, 1'b0, 1'b0, 0, 0, 0);
    cyc_start();
    cmd_valid  = 1'b1;
    cmd_steps  = CNT_W'(5);
    cmd_period = DIV_W'(2);
    cmd_dir    = 1'b1;
    cyc_sample();
    chk("rst-move accept", int'(cmd_ready), 1);
    for (int r = 1; r <= 5; r++) begin
      cyc_start();
      cmd_valid = 1'b0;
      cyc_sample();
      check_cycle(r, 5, 2, 1, 0);
    end
    cyc_start();
    rst = 1'b1;
    cyc_sample();
    chk_reset_outputs("mid-run rst");
    cyc_start();
    rst = 1'b0;
    cyc_sample();
    chk("after rst cmd_ready", int'(cmd_ready), 1);
    chk("after rst steps_left", int'(steps_left), 0);
    chk("after rst step_dir", int'(step_dir), 0);
    chk("after rst aborted", int'(aborted), 0);
    idle(12);

    // Randomized moves, including aborts landing in RUN, SETTLE and IDLE
    for (int k = 0; k < 40; k++) begin
      n     = $urandom_range(0, 8);
      p     = $urandom_range(0, 6);
      ab_at = 0;
      if ($urandom_range(0, 2) == 0) ab_at = $urandom_range(1, n * p_eff(p) + SETTLE + 1);
      run_move(n, p, int'($urandom_range(0, 1)), ab_at, 1'b0, 1'b0, 0, 0, 0);
      idle($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
